// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: MULU/MULS (WIDTH x WIDTH) and DIVU/DIVS (2*WIDTH / WIDTH), one bit per clock.
// Optional divide datapath is built only when MULDIV_DIV_EN is defined; otherwise divide ops exit early as illegal.
module muldiv_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               start_in,
   input  logic [1:0]         op_in,
   input  logic [2*WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               busy_out,
   output logic               done_out,
   output logic [2*WIDTH-1:0] q_out,
   output logic [3:0]         ccr_out
);

   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`ifdef MULDIV_DIV_EN
   localparam int AW = W2;
`else
   localparam int AW = WIDTH;
`endif

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [AW-1:0]     a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [W2-1:0]     q_q, q_d;
   logic [3:0]        ccr_q, ccr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              a_neg_s, b_neg_s;
   logic [WIDTH-1:0]  mag_a_s, mag_b_s;
   logic [WIDTH:0]    sum_s;
   logic [W2-1:0]     prod_s;

   assign a_neg_s = op_q[0] & a_q[WIDTH-1];
   assign b_neg_s = op_q[0] & b_q[WIDTH-1];
   assign mag_a_s = a_neg_s ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
   assign mag_b_s = b_neg_s ? -b_q : b_q;
   // b_q holds the multiplicand magnitude during a multiply
   assign sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
   assign prod_s  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

`ifdef MULDIV_DIV_EN
   logic              rneg_q, rneg_d;
   logic              dneg_s, t_ge_s, ovf_s;
   logic [W2-1:0]     dmag_s;
   logic [WIDTH:0]    t_s;
   logic [WIDTH-1:0]  quo_s, rem_s;

   assign dneg_s = op_q[0] & a_q[W2-1];
   assign dmag_s = dneg_s ? -a_q : a_q;
   assign t_s    = {hi_q, lo_q[WIDTH-1]};
   assign t_ge_s = (t_s >= {1'b0, b_q});
   assign quo_s  = neg_q ? -lo_q : lo_q;
   assign rem_s  = rneg_q ? -hi_q : hi_q;
   // Signed quotient magnitude must fit: < 2^(W-1) if positive, <= 2^(W-1) if negative
   assign ovf_s  = op_q[0] & lo_q[WIDTH-1] & (~neg_q | (|lo_q[WIDTH-2:0]));
`else
   logic unused_s;
   assign unused_s = ^a_in[W2-1:WIDTH];
`endif

   // Next-state, datapath and output-register computation
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      q_d     = q_q;
      ccr_d   = ccr_q;
`ifdef MULDIV_DIV_EN
      rneg_d  = rneg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               state_d = S_PREP;
               op_d    = op_in;
               a_d     = a_in[AW-1:0];
               b_d     = b_in;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREP: begin
            cnt_d = CNT_LAST;
            if (!op_q[1]) begin
               hi_d    = {WIDTH{1'b0}};
               lo_d    = mag_b_s;
               b_d     = mag_a_s;
               neg_d   = a_neg_s ^ b_neg_s;
               state_d = S_CALC;
            end else begin
`ifdef MULDIV_DIV_EN
               hi_d   = dmag_s[W2-1:WIDTH];
               lo_d   = dmag_s[WIDTH-1:0];
               b_d    = mag_b_s;
               neg_d  = dneg_s ^ b_neg_s;
               rneg_d = dneg_s;
               if ((mag_b_s == {WIDTH{1'b0}}) || (dmag_s[W2-1:WIDTH] >= mag_b_s)) begin
                  state_d = S_DONE;
                  q_d     = a_q;
                  ccr_d   = 4'b0010;
               end else begin
                  state_d = S_CALC;
               end
`else
               state_d = S_DONE;
               q_d     = {W2{1'b0}};
               ccr_d   = 4'b0010;
`endif
            end
         end
         S_CALC: begin
`ifdef MULDIV_DIV_EN
            if (op_q[1]) begin
               hi_d = t_ge_s ? (t_s[WIDTH-1:0] - b_q) : t_s[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], t_ge_s};
            end else begin
               hi_d = sum_s[WIDTH:1];
               lo_d = {sum_s[0], lo_q[WIDTH-1:1]};
            end
`else
            hi_d = sum_s[WIDTH:1];
            lo_d = {sum_s[0], lo_q[WIDTH-1:1]};
`endif
            if (cnt_q == {CW{1'b0}}) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         S_FIX: begin
            state_d = S_DONE;
`ifdef MULDIV_DIV_EN
            if (op_q[1]) begin
               if (ovf_s) begin
                  q_d   = a_q;
                  ccr_d = 4'b0010;
               end else begin
                  q_d   = {rem_s, quo_s};
                  ccr_d = {quo_s[WIDTH-1], (quo_s == {WIDTH{1'b0}}), 1'b0, quo_s[0]};
               end
            end else begin
               q_d   = prod_s;
               ccr_d = {prod_s[W2-1], (prod_s == {W2{1'b0}}), 1'b0, prod_s[WIDTH-1]};
            end
`else
            q_d   = prod_s;
            ccr_d = {prod_s[W2-1], (prod_s == {W2{1'b0}}), 1'b0, prod_s[WIDTH-1]};
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_PREP) || (state_d == S_CALC) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         op_q    <= 2'b00;
         a_q     <= {AW{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         neg_q   <= 1'b0;
         q_q     <= {W2{1'b0}};
         ccr_q   <= 4'b0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         q_q     <= q_d;
         ccr_q   <= ccr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef MULDIV_DIV_EN
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign busy_out = busy_q;
   assign done_out = done_q;
   assign q_out    = q_q;
   assign ccr_out  = ccr_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq (WIDTH=16): directed cases, handshake/reset checks and randomized ops against an arithmetic model.
module tb_muldiv_seq;

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk_in;
   logic        rst_in;
   logic        start_in;
   logic [1:0]  op_in;
   logic [31:0] a_in;
   logic [15:0] b_in;
   logic        busy_out;
   logic        done_out;
   logic [31:0] q_out;
   logic [3:0]  ccr_out;

   int vectors;
   int miscompares;

   muldiv_seq #(.WIDTH(16)) dut (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .start_in(start_in),
      .op_in   (op_in),
      .a_in    (a_in),
      .b_in    (b_in),
      .busy_out(busy_out),
      .done_out(done_out),
      .q_out   (q_out),
      .ccr_out (ccr_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Reference: plain integer arithmetic on the operation's definition
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [15:0] b,
                                 output logic [31:0] q, output logic [3:0] ccr, output int lat);
      longint sa, sb, p, ma, mb, quo, rem;
      bit     ovf;
      lat = 19;
      if (op[1] == 1'b0) begin
         if (op[0]) begin
            sa = longint'($signed(a[15:0]));
            sb = longint'($signed(b));
         end else begin
            sa = longint'(a[15:0]);
            sb = longint'(b);
         end
         p   = sa * sb;
         q   = p[31:0];
         ccr = {q[31], q == 32'd0, 1'b0, q[15]};
      end else if (!DIV_EN) begin
         q   = 32'd0;
         ccr = 4'b0010;
         lat = 2;
      end else begin
         if (op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'(a);
            sb = longint'(b);
         end
         ma  = (sa < 64'sd0) ? -sa : sa;
         mb  = (sb < 64'sd0) ? -sb : sb;
         q   = a;
         ccr = 4'b0010;
         if (mb == 64'sd0 || (ma / mb) >= 64'sd65536) begin
            lat = 2;
         end else begin
            quo = sa / sb;
            rem = sa % sb;
            ovf = op[0] && (quo > 64'sd32767 || quo < -64'sd32768);
            if (!ovf) begin
               q   = {rem[15:0], quo[15:0]};
               ccr = {quo[15], quo[15:0] == 16'd0, 1'b0, quo[0]};
            end
         end
      end
   endfunction

   // One transaction from an IDLE cycle; inputs are scrambled after the start edge
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] eq, input logic [3:0] eccr, input int elat);
      int n;
      start_in = 1'b1;
      op_in    = op;
      a_in     = a;
      b_in     = b;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      op_in    = 2'($urandom);
      a_in     = $urandom;
      b_in     = 16'($urandom);
      for (n = 1; n <= 40; n++) begin
         @(negedge clk_in);
         if (done_out === 1'b1) break;
         check({tag, "_busy"}, {31'd0, busy_out}, 32'd1);
         @(posedge clk_in);
      end
      check({tag, "_lat"}, 32'(n), 32'(elat));
      check({tag, "_q"}, q_out, eq);
      check({tag, "_ccr"}, {28'd0, ccr_out}, {28'd0, eccr});
      check({tag, "_busy_done"}, {31'd0, busy_out}, 32'd0);
      @(posedge clk_in);
      @(negedge clk_in);
      check({tag, "_pulse"}, {31'd0, done_out}, 32'd0);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, mq;
      logic [15:0] b;
      logic [3:0]  mc;
      int          ml;
      int          dones;

      vectors     = 0;
      miscompares = 0;
      rst_in      = 1'b1;
      start_in    = 1'b0;
      op_in       = 2'b00;
      a_in        = 32'd0;
      b_in        = 16'd0;
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_busy", {31'd0, busy_out}, 32'd0);
      check("rst_done", {31'd0, done_out}, 32'd0);
      check("rst_q", q_out, 32'd0);
      check("rst_ccr", {28'd0, ccr_out}, 32'd0);
      @(negedge clk_in);
      rst_in = 1'b0;

      run_op("mulu", 2'b00, 32'h0000FFFF, 16'hFFFF, 32'hFFFE0001, 4'b1000, 19);
      run_op("muls", 2'b01, 32'h0000FFFD, 16'h0007, 32'hFFFFFFEB, 4'b1001, 19);
      run_op("divu", 2'b10, 32'h00012345, 16'h0100,
             DIV_EN ? 32'h00450123 : 32'h0, DIV_EN ? 4'b0001 : 4'b0010, DIV_EN ? 19 : 2);
      run_op("divs", 2'b11, 32'hFFFFFF9C, 16'h0007,
             DIV_EN ? 32'hFFFEFFF2 : 32'h0, DIV_EN ? 4'b1000 : 4'b0010, DIV_EN ? 19 : 2);
      run_op("div_mag_ovf", 2'b10, 32'h00010000, 16'h0001,
             DIV_EN ? 32'h00010000 : 32'h0, 4'b0010, 2);
      run_op("div_zero", 2'b10, 32'h12345678, 16'h0000,
             DIV_EN ? 32'h12345678 : 32'h0, 4'b0010, 2);
      run_op("divs_range", 2'b11, 32'h00008000, 16'h0001,
             DIV_EN ? 32'h00008000 : 32'h0, 4'b0010, DIV_EN ? 19 : 2);

      // start held high: accepted at edges 1, 21, 41; ignored while busy and in DONE
      dones    = 0;
      start_in = 1'b1;
      op_in    = 2'b00;
      a_in     = 32'h0000FFFF;
      b_in     = 16'hFFFF;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (done_out === 1'b1) dones++;
      end
      start_in = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (done_out === 1'b1) dones++;
      end
      check("hs_dones", 32'(dones), 32'd3);
      check("hs_q", q_out, 32'hFFFE0001);

      // Reset in the middle of CALC clears everything at once
      start_in = 1'b1;
      op_in    = 2'b01;
      a_in     = 32'h00001234;
      b_in     = 16'h0F0F;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      repeat (9) @(posedge clk_in);
      #2;
      rst_in = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy_out}, 32'd0);
      check("mid_rst_done", {31'd0, done_out}, 32'd0);
      check("mid_rst_q", q_out, 32'd0);
      check("mid_rst_ccr", {28'd0, ccr_out}, 32'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      run_op("post_rst", 2'b00, 32'h0000FFFF, 16'hFFFF, 32'hFFFE0001, 4'b1000, 19);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = 16'($urandom);
         case (i % 4)
            1: a = {{16{a[15]}}, a[15:0]};
            2: a = {16'h0000, a[15:0]};
            3: if (i % 8 == 3) b = 16'h0000; else a = {16'h0000, a[31:16]};
            default: a = a;
         endcase
         model(op, a, b, mq, mc, ml);
         run_op($sformatf("rnd%0d", i), op, a, b, mq, mc, ml);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide unit with parametrised operand width. It supplies the wide arithmetic that the single-cycle ALU cannot: unsigned and signed `WIDTH×WIDTH` multiply, and `2·WIDTH / WIDTH` divide (6309 MULD/DIVD/DIVQ class). It sits beside the ALU in the execute stage and runs one bit per clock under a start/busy/done handshake. The sequencer stalls on `busy_out` and captures the result and flags when `done_out` pulses.

## Interface
- `WIDTH`, default 16: operand width; legal values are even numbers from 8 to 32.
- `clk_in` — in — 1 — clock; all state changes on the rising edge.
- `rst_in` — in — 1 — asynchronous, active-high reset.
- `start_in` — in — 1 — request; sampled only in IDLE.
- `op_in` — in — 2 — operation select:
  - 00 MULU
  - 01 MULS
  - 10 DIVU
  - 11 DIVS
- `a_in` — in — 2·WIDTH — dividend for divide; multiply uses only `a_in[WIDTH-1:0]`.
- `b_in` — in — WIDTH — multiplier or divisor.
- `busy_out` — out — 1 — high from the edge that accepts a start until the edge that enters DONE.
- `done_out` — out — 1 — one-cycle pulse; `q_out` and `ccr_out` are valid while it is high.
- `q_out` — out — 2·WIDTH — result:
  - multiply: product.
  - divide: {remainder, quotient}.
- `ccr_out` — out — 4 — {N, Z, V, C}, aligned to CCR[3:0].

## Operation
- **Operand capture:** operands and op are registered at the start edge; the inputs may change afterwards.
- **States:**
  - **IDLE:** `start_in`=1 moves to PREP. `start_in` is ignored in every other state.
  - **PREP:** takes magnitudes of signed operands and records the result sign.
    - Divide by zero goes to DONE.
    - A magnitude overflow check (|dividend high half| ≥ |divisor|) also goes to DONE.
    - Otherwise loads the bit counter with WIDTH-1 and goes to CALC.
  - **CALC:** one iteration per edge.
    - Multiply: shift-add.
    - Divide: restoring shift-subtract.
    - The counter reaching 0 goes to FIX.
  - **FIX:** applies sign correction.
    - Product is negated if the signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
    - Signed range check: quotient > 2^(WIDTH-1)-1, or < -2^(WIDTH-1), sets V.
    - Goes to DONE.
  - **DONE:** `done_out`=1 and the output registers are loaded; goes to IDLE next edge.
- **Flags:**
  - Multiply: N = q[2W-1], Z = (q==0), V = 0, C = q[W-1].
  - Divide, normal: N = quotient MSB, Z = (quotient==0), V = 0, C = quotient[0].
  - Divide by zero or any overflow: q_out = captured a_in (unchanged dividend), V = 1, N = Z = C = 0.
- **Truncation:** signed division truncates toward zero.
- **Output hold:** `q_out` and `ccr_out` hold their last value until the next DONE.
- **Reset (any time, including mid-CALC):** state goes to IDLE; `busy_out`, `done_out`, `q_out` and `ccr_out` are all 0. No partial result ever appears.

## Timing
- Normal operation, counting the edge that samples `start_in` as edge 1:
  - `done_out` is high after edge WIDTH+3: 1 PREP edge, WIDTH CALC edges, 1 FIX edge, then DONE.
  - That is 19 edges for WIDTH=16.
- Early exit (divide by zero, magnitude overflow): `done_out` is high after edge 2.
- `busy_out`:
  - high after edge 1;
  - low in the DONE cycle;
  - `start_in` in the DONE cycle is ignored.
- Back-to-back: a new start is accepted in the IDLE cycle immediately after DONE.
- The counter is $clog2(WIDTH) bits wide and does not wrap.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- **Defined:** the divide datapath and both divide ops are present as described above.
- **Undefined:** the divide datapath is omitted and only the multiply path is built.
  - `op_in[1]`=1 is still accepted.
  - It takes the early-exit path: `done_out` after edge 2, `q_out` = 0, `ccr_out` = 4'b0010 (V=1, illegal operation).

## Test plan
All scenarios use WIDTH=16.
- **MULU:** a=0x0000FFFF, b=0xFFFF → q_out = 0xFFFE0001, ccr = {1,0,0,0}, `done_out` after edge 19, `busy_out` high for edges 1–18.
- **MULS:** a=0x0000FFFD (-3), b=0x0007 → q_out = 0xFFFFFFEB, ccr = {1,0,0,1}.
- **DIVU:** a=0x00012345, b=0x0100 → q_out = 0x00450123, ccr = {0,0,0,1}; then DIVS a=0xFFFFFF9C (-100), b=0x0007 → q_out = 0xFFFEFFF2 (rem -2, quo -14), ccr = {1,0,0,0}.
- **Early exit:**
  - DIVU a=0x00010000, b=0x0001 → V=1, q_out = 0x00010000, done after edge 2.
  - Divide by zero → same response.
  - DIVS a=0x00008000, b=0x0001 → V=1 from FIX, done after edge 19.
- **Handshake and reset:**
  - Pulse `start_in` every cycle while busy → exactly one `done_out` per accepted start.
  - Assert `rst_in` at CALC edge 8 → all outputs 0 immediately; the next start completes correctly after edge 19.
- **Without `MULDIV_DIV_EN`:** DIVU → q_out = 0, ccr = 4'b0010, done after edge 2; MULU still passes the first scenario.
